autoconfig_sequencer: RTL and testbench

- Autoconfig controller for the combined A500 RAM+IDE card. It presents two Zorro II autoconfig boards, RAM then IDE, one at a time in $E80000 space.
- Latches each board's assigned base and sequences the config chain.
- Tracks 68000 bus cycles and generates the data-output enable, chip selects and DTACK, with programmable wait states on the IDE window.

---
 rtl/autoconfig_sequencer.sv | 110 +++++++++++
 tb/tb_autoconfig_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/autoconfig_sequencer.sv
// autoconfig_sequencer: presents the RAM and IDE autoconfig boards in turn, latches their bases and drives chip selects and DTACK.
module autoconfig_sequencer #(
  parameter logic [15:0] MFG_ID   = 16'hAFFF,
  parameter logic [7:0]  RAM_PROD = 8'hFF,
  parameter logic [7:0]  IDE_PROD = 8'hFE,
  parameter int          IDE_WAIT = 3
) (
  input  logic       cpu_clk,
  input  logic       cpu_reset,
  input  logic [7:0] AH,
  input  logic [5:0] AL,
  input  logic [3:0] D,
  input  logic       cpu_nas,
  input  logic       cpu_rw,
  input  logic       cpu_nlds,
  input  logic       cpu_nuds,
  input  logic       _configin,
  output logic       _configout,
  output logic [3:0] autoconfig_d,
  output logic       autoconfig_oe,
  output logic       dtack,
  output logic       ram_ce,
  output logic       ide_ce
);
  typedef enum logic [1:0] {CFG_RAM, CFG_IDE, DONE} cfg_t;
  typedef enum logic {IDLE, ACTIVE} cyc_t;
  localparam logic [2:0] WAIT = IDE_WAIT[2:0];
  cfg_t cfg_state;
  cyc_t cyc;
  logic nas_z, ac_l, ram_l, ide_l, wdone, ram_en, ide_en;
  logic [2:0] ram_base, cnt, cnt_nx;
  logic [7:0] ide_base;
  logic [3:0] ide_lo, nib, mfg;
  logic start, ac_hit, ide_match, ram_match, wr, ide_brd;
  logic [7:0] prod;
  assign start = !cpu_nas & nas_z;
  assign ac_hit = (AH == 8'hE8) & (cfg_state != DONE) & !_configin;
  assign ide_match = ide_en & (AH == ide_base);
  assign ram_match = ram_en & (AH[7:5] == ram_base);
  assign ide_ce = ide_match & (cyc == ACTIVE);
  assign ram_ce = ram_match & !ide_ce;
  assign autoconfig_oe = (cyc == ACTIVE) & ac_l & cpu_rw;
  assign _configout = cfg_state != DONE;
  assign wr = (cyc == ACTIVE) & !cpu_nas & !cpu_rw & !(cpu_nlds & cpu_nuds) & ac_l & !wdone;
  assign cnt_nx = (cnt == 3'd7) ? 3'd7 : cnt + 3'd1;
  assign ide_brd = cfg_state != CFG_RAM;
  assign prod = ide_brd ? IDE_PROD : RAM_PROD;
  always_comb begin
    mfg = AL[1:0] == 2'd0 ? MFG_ID[15:12] : AL[1:0] == 2'd1 ? MFG_ID[11:8] :
          AL[1:0] == 2'd2 ? MFG_ID[7:4] : MFG_ID[3:0];
    nib = AL == 6'h00 ? (ide_brd ? 4'hD : 4'hE) :
          AL == 6'h01 ? (ide_brd ? 4'h1 : 4'h6) :
          AL == 6'h02 ? prod[7:4] :
          AL == 6'h03 ? prod[3:0] :
          AL == 6'h04 ? (ide_brd ? 4'hF : 4'h3) :
          AL[5:2] == 4'h2 ? mfg :
          AL[5:1] == 5'h10 ? 4'h0 : 4'hF;
  end
  // decode is frozen at the start edge so a config commit only affects the following cycle
  always_ff @(posedge cpu_clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      cfg_state <= CFG_RAM;
      cyc <= IDLE;
      nas_z <= 1'b1;
      {ac_l, ram_l, ide_l, wdone, ram_en, ide_en, dtack} <= '0;
      ram_base <= '0;
      ide_base <= '0;
      ide_lo <= '0;
      cnt <= '0;
      autoconfig_d <= 4'hF;
    end else begin
      nas_z <= cpu_nas;
      if (start) begin
        cyc <= ACTIVE;
        ac_l <= ac_hit;
        ram_l <= ram_match & !ide_match;
        ide_l <= ide_match;
        cnt <= '0;
        wdone <= 1'b0;
        dtack <= 1'b0;
        autoconfig_d <= nib;
      end else if (cyc == ACTIVE) begin
        if (cpu_nas) begin
          cyc <= IDLE;
          dtack <= 1'b0;
        end else begin
          cnt <= cnt_nx;
          dtack <= ac_l | ram_l | (ide_l & (dtack | cnt_nx == WAIT | WAIT == 3'd0));
          if (wr) begin
            wdone <= 1'b1;
            if (cfg_state == CFG_RAM) begin
              if (AL == 6'h24) begin
                ram_base <= D[3:1];
                ram_en <= 1'b1;
                cfg_state <= CFG_IDE;
              end else if (AL == 6'h26) cfg_state <= CFG_IDE;
            end else if (cfg_state == CFG_IDE) begin
              if (AL == 6'h25) ide_lo <= D;
              else if (AL == 6'h24) begin
                ide_base <= {D, ide_lo};
                ide_en <= 1'b1;
                cfg_state <= DONE;
              end else if (AL == 6'h26) cfg_state <= DONE;
            end
          end
        end
      end else wdone <= 1'b0;
    end
  end
endmodule

// File: tb/tb_autoconfig_sequencer.sv
// tb_autoconfig_sequencer: vector table, corner sequences and random bus cycles against a board-level model.
module tb_autoconfig_sequencer;
  localparam int W0 = 3, W1 = 0;
  logic cpu_clk = 0, cpu_reset = 1;
  logic [7:0] AH = 0;
  logic [5:0] AL = 0;
  logic [3:0] D = 0;
  logic cpu_nas = 1, cpu_rw = 1, cpu_nlds = 1, cpu_nuds = 1, _configin = 0;
  logic cfgout0, oe0, dtack0, ram0, ide0, cfgout1, oe1, dtack1, ram1, ide1;
  logic [3:0] ad0, ad1;
  always #5 cpu_clk = ~cpu_clk;

  autoconfig_sequencer #(.IDE_WAIT(W0)) u0 (
    .cpu_clk(cpu_clk), .cpu_reset(cpu_reset), .AH(AH), .AL(AL), .D(D), .cpu_nas(cpu_nas),
    .cpu_rw(cpu_rw), .cpu_nlds(cpu_nlds), .cpu_nuds(cpu_nuds), ._configin(_configin),
    ._configout(cfgout0), .autoconfig_d(ad0), .autoconfig_oe(oe0), .dtack(dtack0),
    .ram_ce(ram0), .ide_ce(ide0));
  autoconfig_sequencer #(.IDE_WAIT(W1)) u1 (
    .cpu_clk(cpu_clk), .cpu_reset(cpu_reset), .AH(AH), .AL(AL), .D(D), .cpu_nas(cpu_nas),
    .cpu_rw(cpu_rw), .cpu_nlds(cpu_nlds), .cpu_nuds(cpu_nuds), ._configin(_configin),
    ._configout(cfgout1), .autoconfig_d(ad1), .autoconfig_oe(oe1), .dtack(dtack1),
    .ram_ce(ram1), .ide_ce(ide1));

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // model: 0 = RAM board, 1 = IDE board, 2 = done
  int m_cfg;
  bit m_ram_en, m_ide_en;
  bit [2:0] m_ram_base;
  bit [7:0] m_ide_base;
  bit [3:0] m_ide_lo;
  bit [3:0] rom [2][64];

  function automatic void m_reset();
    m_cfg = 0; m_ram_en = 0; m_ide_en = 0; m_ram_base = 0; m_ide_base = 0; m_ide_lo = 0;
  endfunction

  function automatic void m_write(input bit [7:0] off, input bit [3:0] d);
    if (m_cfg == 0 && off == 8'h48) begin m_ram_base = d[3:1]; m_ram_en = 1; m_cfg = 1; end
    else if (m_cfg == 0 && off == 8'h4C) m_cfg = 1;
    else if (m_cfg == 1 && off == 8'h4A) m_ide_lo = d;
    else if (m_cfg == 1 && off == 8'h48) begin m_ide_base = {d, m_ide_lo}; m_ide_en = 1; m_cfg = 2; end
    else if (m_cfg == 1 && off == 8'h4C) m_cfg = 2;
  endfunction

  function automatic int dk_exp(input bit fast, input bit ide, input int w);
    return fast ? 1 : ide ? (w < 1 ? 1 : w) : -1;
  endfunction

  logic [3:0] s_d;
  logic s_oe, s_ide, s_ram, s_cfg;
  int s_dk0, s_dk1;

  task automatic bus(input logic [7:0] ah, input logic [5:0] al, input logic rw, input logic [3:0] d,
                     input logic lds, input logic uds, input logic cfgin);
    bit ac, ide_l, ram_l, ide_now, ram_now, dvalid;
    bit [3:0] ed;
    int e0, e1;
    @(negedge cpu_clk);
    AH = ah; AL = al; cpu_rw = rw; D = d; cpu_nlds = lds; cpu_nuds = uds; _configin = cfgin;
    @(negedge cpu_clk);
    cpu_nas = 0;
    ac = ah == 8'hE8 && m_cfg != 2 && !cfgin;
    ide_l = m_ide_en && ah == m_ide_base;
    ram_l = m_ram_en && ah[7:5] == m_ram_base && !ide_l;
    e0 = dk_exp(ac || ram_l, ide_l, W0);
    e1 = dk_exp(ac || ram_l, ide_l, W1);
    dvalid = m_cfg != 2;
    ed = dvalid ? rom[m_cfg][al] : 4'hF;
    s_dk0 = -1; s_dk1 = -1;
    for (int k = 0; k < 6; k++) begin
      @(negedge cpu_clk);
      if (k == 1 && ac && !rw && !(lds && uds)) m_write({1'b0, al, 1'b0}, d);
      ide_now = m_ide_en && ah == m_ide_base;
      ram_now = m_ram_en && ah[7:5] == m_ram_base && !ide_now;
      chk("oe", int'(oe0), int'(ac && rw));
      chk("dtack_w3", int'(dtack0), int'(e0 >= 0 && k >= e0));
      chk("dtack_w0", int'(dtack1), int'(e1 >= 0 && k >= e1));
      chk("ide_ce", int'(ide0), int'(ide_now));
      chk("ram_ce", int'(ram0), int'(ram_now));
      if (k == 0) begin
        if (dvalid) chk("acd", int'(ad0), int'(ed));
        s_d = ad0; s_oe = oe0; s_ide = ide0; s_ram = ram0;
      end
      if (s_dk0 < 0 && dtack0) s_dk0 = k;
      if (s_dk1 < 0 && dtack1) s_dk1 = k;
    end
    cpu_nas = 1;
    @(negedge cpu_clk);
    chk("end_dtack", int'(dtack0 | dtack1), 0);
    chk("end_oe", int'(oe0), 0);
    chk("end_ide", int'(ide0), 0);
    chk("end_ram", int'(ram0), int'(m_ram_en && AH[7:5] == m_ram_base));
    chk("cfgout", int'(cfgout0), int'(m_cfg != 2));
    s_cfg = cfgout0;
  endtask

  task automatic do_reset();
    @(negedge cpu_clk);
    cpu_reset = 1; cpu_nas = 1; cpu_rw = 1; cpu_nlds = 1; cpu_nuds = 1;
    repeat (2) @(negedge cpu_clk);
    cpu_reset = 0;
    m_reset();
  endtask

  typedef struct {
    logic [7:0] ah; logic [5:0] al; logic rw; logic [3:0] d;
    logic chk_d; logic [3:0] ed; logic eoe; int edk0; int edk1; logic eram; logic eide; logic ecfg;
  } vec_t;
  vec_t tbl [23];
  logic [5:0] als [14] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0A, 6'h0B,
                           6'h20, 6'h21, 6'h24, 6'h25, 6'h26};

  initial begin
    for (int b = 0; b < 2; b++) for (int a = 0; a < 64; a++) rom[b][a] = 4'hF;
    rom[0][0] = 4'hE; rom[0][1] = 4'h6; rom[0][2] = 4'hF; rom[0][3] = 4'hF; rom[0][4] = 4'h3;
    rom[1][0] = 4'hD; rom[1][1] = 4'h1; rom[1][2] = 4'hF; rom[1][3] = 4'hE; rom[1][4] = 4'hF;
    for (int b = 0; b < 2; b++) begin
      rom[b][8] = 4'hA; rom[b][9] = 4'hF; rom[b][10] = 4'hF; rom[b][11] = 4'hF;
      rom[b][32] = 4'h0; rom[b][33] = 4'h0;
    end
    tbl[0]  = '{8'hE8, 6'h00, 1, 4'h0, 1, 4'hE, 1, 1, 1, 0, 0, 1};
    tbl[1]  = '{8'hE8, 6'h01, 1, 4'h0, 1, 4'h6, 1, 1, 1, 0, 0, 1};
    tbl[2]  = '{8'hE8, 6'h02, 1, 4'h0, 1, 4'hF, 1, 1, 1, 0, 0, 1};
    tbl[3]  = '{8'hE8, 6'h03, 1, 4'h0, 1, 4'hF, 1, 1, 1, 0, 0, 1};
    tbl[4]  = '{8'hE8, 6'h04, 1, 4'h0, 1, 4'h3, 1, 1, 1, 0, 0, 1};
    tbl[5]  = '{8'hE8, 6'h08, 1, 4'h0, 1, 4'hA, 1, 1, 1, 0, 0, 1};
    tbl[6]  = '{8'hE8, 6'h0B, 1, 4'h0, 1, 4'hF, 1, 1, 1, 0, 0, 1};
    tbl[7]  = '{8'hE8, 6'h20, 1, 4'h0, 1, 4'h0, 1, 1, 1, 0, 0, 1};
    tbl[8]  = '{8'hE8, 6'h25, 0, 4'h5, 1, 4'hF, 0, 1, 1, 0, 0, 1};
    tbl[9]  = '{8'hE8, 6'h00, 1, 4'h0, 1, 4'hE, 1, 1, 1, 0, 0, 1};
    tbl[10] = '{8'hE8, 6'h24, 0, 4'h2, 1, 4'hF, 0, 1, 1, 0, 0, 1};
    tbl[11] = '{8'hE8, 6'h00, 1, 4'h0, 1, 4'hD, 1, 1, 1, 0, 0, 1};
    tbl[12] = '{8'hE8, 6'h01, 1, 4'h0, 1, 4'h1, 1, 1, 1, 0, 0, 1};
    tbl[13] = '{8'hE8, 6'h03, 1, 4'h0, 1, 4'hE, 1, 1, 1, 0, 0, 1};
    tbl[14] = '{8'hE8, 6'h04, 1, 4'h0, 1, 4'hF, 1, 1, 1, 0, 0, 1};
    tbl[15] = '{8'h20, 6'h00, 1, 4'h0, 1, 4'hD, 0, 1, 1, 1, 0, 1};
    tbl[16] = '{8'h40, 6'h00, 1, 4'h0, 1, 4'hD, 0, -1, -1, 0, 0, 1};
    tbl[17] = '{8'hE8, 6'h25, 0, 4'h0, 1, 4'hF, 0, 1, 1, 0, 0, 1};
    tbl[18] = '{8'hE8, 6'h24, 0, 4'hE, 1, 4'hF, 0, 1, 1, 0, 0, 0};
    tbl[19] = '{8'hE8, 6'h00, 1, 4'h0, 0, 4'h0, 0, -1, -1, 0, 0, 0};
    tbl[20] = '{8'hE0, 6'h08, 1, 4'h0, 0, 4'h0, 0, 3, 1, 0, 1, 0};
    tbl[21] = '{8'h20, 6'h00, 1, 4'h0, 0, 4'h0, 0, 1, 1, 1, 0, 0};
    tbl[22] = '{8'h3F, 6'h00, 1, 4'h0, 0, 4'h0, 0, 1, 1, 1, 0, 0};

    m_reset();
    @(negedge cpu_clk);
    chk("rst_oe", int'(oe0), 0);
    chk("rst_dtack", int'(dtack0), 0);
    chk("rst_ram", int'(ram0), 0);
    chk("rst_ide", int'(ide0), 0);
    chk("rst_cfgout", int'(cfgout0), 1);
    chk("rst_d", int'(ad0), 15);
    cpu_reset = 0;

    for (int i = 0; i < 23; i++) begin
      bus(tbl[i].ah, tbl[i].al, tbl[i].rw, tbl[i].d, 1'b0, 1'b0, 1'b0);
      if (tbl[i].chk_d) chk($sformatf("v%0d_d", i), int'(s_d), int'(tbl[i].ed));
      chk($sformatf("v%0d_oe", i), int'(s_oe), int'(tbl[i].eoe));
      chk($sformatf("v%0d_dk3", i), s_dk0, tbl[i].edk0);
      chk($sformatf("v%0d_dk0", i), s_dk1, tbl[i].edk1);
      chk($sformatf("v%0d_ram", i), int'(s_ram), int'(tbl[i].eram));
      chk($sformatf("v%0d_ide", i), int'(s_ide), int'(tbl[i].eide));
      chk($sformatf("v%0d_cfgout", i), int'(s_cfg), int'(tbl[i].ecfg));
    end

    // configin high: card stays invisible and unconfigured
    do_reset();
    bus(8'hE8, 6'h24, 1'b0, 4'h2, 1'b0, 1'b0, 1'b1);
    chk("cin_dtack", s_dk0, -1);
    chk("cin_cfgout", int'(s_cfg), 1);
    bus(8'hE8, 6'h00, 1'b1, 4'h0, 1'b1, 1'b1, 1'b1);
    chk("cin_oe", int'(s_oe), 0);
    bus(8'hE8, 6'h00, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0);
    chk("cin_held_d", int'(s_d), 14);

    // reset in the middle of an IDE cycle after configuration completes
    bus(8'hE8, 6'h24, 1'b0, 4'h2, 1'b0, 1'b1, 1'b0);
    bus(8'hE8, 6'h24, 1'b0, 4'hE, 1'b1, 1'b0, 1'b0);
    chk("mid_cfgout_done", int'(s_cfg), 0);
    @(negedge cpu_clk);
    AH = 8'hE0; AL = 6'h08; cpu_rw = 1; cpu_nlds = 0; cpu_nuds = 0;
    @(negedge cpu_clk);
    cpu_nas = 0;
    repeat (4) @(negedge cpu_clk);
    chk("mid_dtack_pre", int'(dtack0), 1);
    chk("mid_ide_pre", int'(ide0), 1);
    #2 cpu_reset = 1;
    #1;
    chk("mid_dtack", int'(dtack0), 0);
    chk("mid_ide", int'(ide0), 0);
    chk("mid_ram", int'(ram0), 0);
    chk("mid_oe", int'(oe0), 0);
    chk("mid_cfgout", int'(cfgout0), 1);
    chk("mid_d", int'(ad0), 15);
    @(negedge cpu_clk);
    cpu_nas = 1;
    @(negedge cpu_clk);
    cpu_reset = 0;
    m_reset();
    bus(8'hE8, 6'h00, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0);
    chk("mid_reconf_d", int'(s_d), 14);

    for (int i = 0; i < 120; i++) begin
      int r;
      logic [7:0] ah;
      logic [5:0] al;
      if (i % 25 == 0) do_reset();
      r = $urandom_range(0, 9);
      ah = r < 6 ? 8'hE8 : r < 8 ? 8'($urandom) : (m_ide_en ? m_ide_base : 8'($urandom));
      al = $urandom_range(0, 4) == 0 ? 6'($urandom) : als[$urandom_range(0, 13)];
      bus(ah, al, 1'($urandom), 4'($urandom), 1'($urandom_range(0, 9) < 3),
          1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
